// File: rtl/memif_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memif_pkg                                                          |
// | Shared definitions for the memif_stream SPI memory interface:      |
// | chunk tag constants, the frame FSM state type and the generic      |
// | packet pack/unpack helpers (widths passed as arguments).           |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package memif_pkg;

   localparam logic [1:0] TAG_FIRST = 2'b01;
   localparam logic [1:0] TAG_MID   = 2'b00;
   localparam logic [1:0] TAG_LAST  = 2'b10;

   // Upper bounds for the generic helpers; callers cast to their real widths.
   localparam int MAX_WORD   = 64;
   localparam int MAX_CHUNKS = 64;
   localparam int MAX_PKT    = MAX_WORD + 2 * MAX_CHUNKS;

   typedef enum logic [1:0] {
      GET_RD_ADDR = 2'd0,
      GET_WR_ADDR = 2'd1,
      STREAM      = 2'd2
   } memif_state_t;

   typedef struct packed {
      logic                valid;
      logic [MAX_WORD-1:0] word;
   } unpacked_t;

   // Tag expected on chunk k, counted from the LSB end (k = chunks-1 is sent first).
   function automatic logic [1:0] chunk_tag(input int k, input int chunks);
      if (k == chunks - 1) return TAG_FIRST;
      else if (k == 0)     return TAG_LAST;
      else                 return TAG_MID;
   endfunction

   function automatic logic [MAX_PKT-1:0] pack_word(input logic [MAX_WORD-1:0] word,
                                                    input int chunk_w, input int chunks);
      logic [MAX_PKT-1:0]  pkt;
      logic [MAX_PKT-1:0]  chunk;
      logic [MAX_PKT-1:0]  mask;
      logic [MAX_WORD-1:0] rest;
      pkt  = '0;
      rest = word;
      mask = (MAX_PKT'(1) << chunk_w) - MAX_PKT'(1);
      for (int k = 0; k < MAX_CHUNKS; k++) begin
         if (k < chunks) begin
            chunk = (MAX_PKT'(chunk_tag(k, chunks)) << chunk_w) | (MAX_PKT'(rest) & mask);
            pkt   = pkt | (chunk << (k * (chunk_w + 2)));
            rest  = rest >> chunk_w;
         end
      end
      return pkt;
   endfunction

   function automatic unpacked_t unpack_word(input logic [MAX_PKT-1:0] pkt,
                                             input int chunk_w, input int chunks);
      unpacked_t          res;
      logic [MAX_PKT-1:0] chunk;
      logic [MAX_PKT-1:0] mask;
      res.valid = 1'b1;
      res.word  = '0;
      mask      = (MAX_PKT'(1) << chunk_w) - MAX_PKT'(1);
      for (int k = 0; k < MAX_CHUNKS; k++) begin
         if (k < chunks) begin
            chunk = pkt >> (k * (chunk_w + 2));
            if (2'(chunk >> chunk_w) != chunk_tag(k, chunks)) res.valid = 1'b0;
            res.word = res.word | (MAX_WORD'(chunk & mask) << (k * chunk_w));
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/memif_packet_codec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memif_packet_codec                                                 |
// | Combinational packet codec.                                        |
// |   in_packet_i  : received tagged packet                            |
// |   word_o       : payload word extracted from in_packet_i           |
// |   valid_o      : all chunk tags are in their legal positions       |
// |   out_word_i   : word to be transmitted                            |
// |   out_packet_o : tagged packet built from out_word_i               |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module memif_packet_codec
   import memif_pkg::*;
#(
   parameter  int WORD_WIDTH   = 8,
   parameter  int CHUNK_WIDTH  = 4,
   localparam int CHUNKS       = WORD_WIDTH / CHUNK_WIDTH,
   localparam int PACKET_WIDTH = WORD_WIDTH + 2 * CHUNKS
) (
   input  logic [PACKET_WIDTH-1:0] in_packet_i,
   output logic [WORD_WIDTH-1:0]   word_o,
   output logic                    valid_o,
   input  logic [WORD_WIDTH-1:0]   out_word_i,
   output logic [PACKET_WIDTH-1:0] out_packet_o
);

   unpacked_t unpacked;

   always_comb begin
      unpacked = unpack_word(MAX_PKT'(in_packet_i), CHUNK_WIDTH, CHUNKS);
   end

   assign word_o       = WORD_WIDTH'(unpacked.word);
   assign valid_o      = unpacked.valid;
   assign out_packet_o = PACKET_WIDTH'(pack_word(MAX_WORD'(out_word_i), CHUNK_WIDTH, CHUNKS));

endmodule
`default_nettype wire

// File: rtl/memif_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memif_stream                                                       |
// | Frame decoder between the SPI serdes and a dual-port memory.       |
// | Frame = read-address packet, write-address packet, data packets.   |
// |   clk, reset        : clock, async active-high reset               |
// |   frameStart        : chip-select pulse, restarts the frame        |
// |   dataReady/inPacket: received packet strobe and contents          |
// |   outPacket         : prefetched read word, tagged for transmit    |
// |   rd_addr/rd_data   : memory read port (1-cycle registered data)   |
// |   wr_addr/wr_data/wr_enable : memory write port                    |
// |   inPacketIsValid   : tag check result of the last packet          |
// |   errCount          : saturating invalid-packet counter            |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module memif_stream
   import memif_pkg::*;
#(
   parameter  int WORD_WIDTH   = 8,
   parameter  int ADDR_WIDTH   = 8,
   parameter  int CHUNK_WIDTH  = 4,
   parameter  int ERR_WIDTH    = 8,
   localparam int CHUNKS       = WORD_WIDTH / CHUNK_WIDTH,
   localparam int PACKET_WIDTH = WORD_WIDTH + 2 * CHUNKS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frameStart,
   input  logic                    dataReady,
   input  logic [PACKET_WIDTH-1:0] inPacket,
   output logic [PACKET_WIDTH-1:0] outPacket,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [WORD_WIDTH-1:0]   rd_data,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [WORD_WIDTH-1:0]   wr_data,
   output logic                    wr_enable,
   output logic                    inPacketIsValid,
   output logic [ERR_WIDTH-1:0]    errCount
);

   localparam logic [PACKET_WIDTH-1:0] RESET_PACKET =
      PACKET_WIDTH'(pack_word('0, CHUNK_WIDTH, CHUNKS));

   memif_state_t            state_q, state_d, eff_state;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [WORD_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                    wr_en_q, wr_en_d;
   logic                    valid_q, valid_d;
   logic [ERR_WIDTH-1:0]    err_q, err_d;
   logic [PACKET_WIDTH-1:0] out_q, out_d;
   // fetch_q[0]: rd_addr loaded last edge; fetch_q[1]: rd_data now holds that word.
   logic [1:0]              fetch_q, fetch_d;

   logic [WORD_WIDTH-1:0]   pkt_word;
   logic                    pkt_valid;
   logic [PACKET_WIDTH-1:0] rd_packet;

   memif_packet_codec #(
      .WORD_WIDTH  (WORD_WIDTH),
      .CHUNK_WIDTH (CHUNK_WIDTH)
   ) u_codec (
      .in_packet_i  (inPacket),
      .word_o       (pkt_word),
      .valid_o      (pkt_valid),
      .out_word_i   (rd_data),
      .out_packet_o (rd_packet)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= GET_RD_ADDR;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= '0;
         out_q     <= RESET_PACKET;
         fetch_q   <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         out_q     <= out_d;
         fetch_q   <= fetch_d;
      end
   end

   always_comb begin
      // A coincident frameStart makes this packet the new frame's read address.
      eff_state = frameStart ? GET_RD_ADDR : state_q;
      state_d   = eff_state;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      valid_d   = valid_q;
      err_d     = err_q;
      out_d     = out_q;
      fetch_d   = {fetch_q[0], 1'b0};

      // Post-increment lands one cycle after the strobe so the memory sees
      // the address that was presented together with wr_enable.
      if (wr_en_q) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      if (fetch_q[1]) out_d = rd_packet;

      if (dataReady) begin
         valid_d = pkt_valid;
         if (pkt_valid) begin
            case (eff_state)
               GET_RD_ADDR: begin
                  rd_addr_d  = pkt_word[ADDR_WIDTH-1:0];
                  fetch_d[0] = 1'b1;
                  state_d    = GET_WR_ADDR;
               end
               GET_WR_ADDR: begin
                  wr_addr_d = pkt_word[ADDR_WIDTH-1:0];
                  state_d   = STREAM;
               end
               STREAM: begin
                  wr_en_d    = 1'b1;
                  wr_data_d  = pkt_word;
                  rd_addr_d  = rd_addr_q + ADDR_WIDTH'(1);
                  fetch_d[0] = 1'b1;
               end
               default: state_d = GET_RD_ADDR;
            endcase
         end else if (err_q != {ERR_WIDTH{1'b1}}) begin
            err_d = err_q + ERR_WIDTH'(1);
         end
      end
   end

   assign outPacket       = out_q;
   assign rd_addr         = rd_addr_q;
   assign wr_addr         = wr_addr_q;
   assign wr_data         = wr_data_q;
   assign wr_enable       = wr_en_q;
   assign inPacketIsValid = valid_q;
   assign errCount        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_memif_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_memif_stream                                                    |
// | Bench for memif_stream: reference model of the frame protocol plus |
// | directed literal checks and a randomized packet stream; a second   |
// | instance exercises a 16-bit / 4-chunk configuration.               |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_memif_stream;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frameStart = 1'b0;
   logic        dataReady = 1'b0;
   logic [11:0] inPacket = '0;
   logic [11:0] outPacket;
   logic [7:0]  rd_addr, wr_addr, wr_data, errCount;
   logic [7:0]  rd_data = '0;
   logic        wr_enable, inPacketIsValid;

   logic        fs2 = 1'b0;
   logic        dr2 = 1'b0;
   logic [23:0] pkt2 = '0;
   logic [23:0] out2;
   logic [7:0]  rd2, wr2, err2;
   logic [15:0] rdd2 = '0;
   logic [15:0] wd2;
   logic        we2, v2;

   int n_vec = 0;
   int n_err = 0;
   bit started = 1'b0;

   memif_stream dut (
      .clk(clk), .reset(reset), .frameStart(frameStart), .dataReady(dataReady),
      .inPacket(inPacket), .outPacket(outPacket), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
      .inPacketIsValid(inPacketIsValid), .errCount(errCount)
   );

   memif_stream #(.WORD_WIDTH(16), .ADDR_WIDTH(8), .CHUNK_WIDTH(4), .ERR_WIDTH(8)) dut16 (
      .clk(clk), .reset(reset), .frameStart(fs2), .dataReady(dr2),
      .inPacket(pkt2), .outPacket(out2), .rd_addr(rd2), .rd_data(rdd2),
      .wr_addr(wr2), .wr_data(wd2), .wr_enable(we2),
      .inPacketIsValid(v2), .errCount(err2)
   );

   initial forever #5 clk = ~clk;

   // Fake memories: registered read returning the address itself.
   always @(posedge clk) begin
      rd_data <= rd_addr;
      rdd2    <= {8'h00, rd2};
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model (arithmetic on integers) ----------------
   function automatic longint pack_m(input longint w, input int ww, input int cw);
      int     n;
      longint p, tag, pay;
      n = ww / cw;
      p = 0;
      for (int c = 0; c < n; c++) begin
         tag = (c == 0) ? 1 : ((c == n - 1) ? 2 : 0);
         pay = (w >> (cw * (n - 1 - c))) % (longint'(1) << cw);
         p   = p * (longint'(1) << (cw + 2)) + tag * (longint'(1) << cw) + pay;
      end
      return p;
   endfunction

   function automatic bit unpack_m(input longint p, input int ww, input int cw, output longint w);
      int     n;
      bit     ok;
      longint chunk, tag, want;
      n  = ww / cw;
      ok = 1'b1;
      w  = 0;
      for (int c = 0; c < n; c++) begin
         chunk = (p >> ((cw + 2) * (n - 1 - c))) % (longint'(1) << (cw + 2));
         tag   = chunk >> cw;
         want  = (c == 0) ? 1 : ((c == n - 1) ? 2 : 0);
         if (tag != want) ok = 1'b0;
         w = w * (longint'(1) << cw) + chunk % (longint'(1) << cw);
      end
      return ok;
   endfunction

   // Expected visible outputs; frame phase 0 = read addr, 1 = write addr, 2 = data.
   int     cyc = 0;
   int     m_phase = 0;
   longint m_rd = 0, m_wr = 0, m_wrdata = 0, m_err = 0, m_out = 'h420;
   bit     m_wren = 0, m_valid = 0;
   int     fq_due[$];
   longint fq_val[$];

   task automatic model_step();
      longint w;
      bit     ok;
      int     ph;
      if (reset) begin
         m_phase = 0; m_rd = 0; m_wr = 0; m_wrdata = 0; m_err = 0;
         m_wren = 0; m_valid = 0; m_out = pack_m(0, 8, 4);
         fq_due.delete(); fq_val.delete();
         return;
      end
      cyc++;
      // A write strobed last cycle advances the write address now.
      if (m_wren) m_wr = (m_wr + 1) % 256;
      m_wren = 0;
      // Read word reaches outPacket two cycles after its address was set.
      if (fq_due.size() > 0 && fq_due[0] == cyc) begin
         m_out = pack_m(fq_val[0], 8, 4);
         void'(fq_due.pop_front());
         void'(fq_val.pop_front());
      end
      ph = frameStart ? 0 : m_phase;
      m_phase = ph;
      if (dataReady) begin
         ok = unpack_m(longint'(inPacket), 8, 4, w);
         m_valid = ok;
         if (!ok) m_err = (m_err < 255) ? m_err + 1 : 255;
         else if (ph == 0) begin
            m_rd = w % 256; m_phase = 1;
            fq_due.push_back(cyc + 2); fq_val.push_back(m_rd);
         end else if (ph == 1) begin
            m_wr = w % 256; m_phase = 2;
         end else begin
            m_wren = 1; m_wrdata = w; m_rd = (m_rd + 1) % 256;
            fq_due.push_back(cyc + 2); fq_val.push_back(m_rd);
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge reset);
      model_step();
      started = 1'b1;
   end

   // Compare DUT against the model on every falling edge.
   initial forever begin
      @(negedge clk);
      if (started) begin
         check("rd_addr",   64'(rd_addr),         64'(m_rd));
         check("wr_addr",   64'(wr_addr),         64'(m_wr));
         check("wr_data",   64'(wr_data),         64'(m_wrdata));
         check("wr_enable", 64'(wr_enable),       64'(m_wren));
         check("valid",     64'(inPacketIsValid), 64'(m_valid));
         check("errCount",  64'(errCount),        64'(m_err));
         check("outPacket", 64'(outPacket),       64'(m_out));
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_fs();
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
   endtask

   // Returns at the falling edge just after the sampling edge.
   task automatic send(input logic [11:0] p, input bit fs);
      inPacket   = p;
      dataReady  = 1'b1;
      frameStart = fs;
      @(negedge clk);
      dataReady  = 1'b0;
      frameStart = 1'b0;
   endtask

   function automatic logic [11:0] pk8(input logic [7:0] w);
      return 12'(pack_m(longint'(w), 8, 4));
   endfunction

   initial begin
      logic [11:0] p;
      int          r;
      idle(3);
      check("reset_out", 64'(outPacket), 64'h420);
      check("reset_err", 64'(errCount), 64'h0);
      reset = 1'b0;
      idle(1);

      // Basic frame
      pulse_fs();
      send(12'h425, 1'b0);
      check("bf_rd", 64'(rd_addr), 64'h05);
      check("bf_valid", 64'(inPacketIsValid), 64'h1);
      idle(2);
      check("bf_out", 64'(outPacket), 64'h425);
      send(12'h42D, 1'b0);
      check("bf_wr", 64'(wr_addr), 64'h0D);
      idle(2);
      send(12'h56F, 1'b0);
      check("bf_we", 64'(wr_enable), 64'h1);
      check("bf_wdata", 64'(wr_data), 64'h5F);
      check("bf_waddr", 64'(wr_addr), 64'h0D);
      idle(1);
      check("bf_we_off", 64'(wr_enable), 64'h0);
      check("bf_winc", 64'(wr_addr), 64'h0E);
      check("bf_rinc", 64'(rd_addr), 64'h06);
      idle(1);
      check("bf_out2", 64'(outPacket), 64'h426);

      // Invalid tag in stream
      send(12'hC25, 1'b0);
      check("inv_valid", 64'(inPacketIsValid), 64'h0);
      check("inv_err", 64'(errCount), 64'h1);
      check("inv_we", 64'(wr_enable), 64'h0);
      check("inv_wr", 64'(wr_addr), 64'h0E);
      check("inv_rd", 64'(rd_addr), 64'h06);
      idle(2);
      send(pk8(8'hA5), 1'b0);
      check("inv_next_we", 64'(wr_enable), 64'h1);
      check("inv_next_wr", 64'(wr_addr), 64'h0E);
      check("inv_next_wd", 64'(wr_data), 64'hA5);
      idle(2);

      // Write address wrap
      pulse_fs();
      send(pk8(8'h10), 1'b0); idle(2);
      send(pk8(8'hFF), 1'b0); idle(2);
      send(pk8(8'h11), 1'b0);
      check("wrap_we1", 64'(wr_enable), 64'h1);
      check("wrap_a1", 64'(wr_addr), 64'hFF);
      idle(2);
      send(pk8(8'h22), 1'b0);
      check("wrap_we2", 64'(wr_enable), 64'h1);
      check("wrap_a2", 64'(wr_addr), 64'h00);
      idle(2);

      // Restart coincident with data
      send(12'h42A, 1'b1);
      check("rs_rd", 64'(rd_addr), 64'h0A);
      check("rs_we", 64'(wr_enable), 64'h0);
      idle(2);
      send(pk8(8'h33), 1'b0);
      check("rs_wr", 64'(wr_addr), 64'h33);
      check("rs_we2", 64'(wr_enable), 64'h0);
      idle(2);

      // Async reset during a write strobe
      send(pk8(8'h77), 1'b0);
      check("rst_pre_we", 64'(wr_enable), 64'h1);
      #2 reset = 1'b1;
      #1;
      check("rst_we", 64'(wr_enable), 64'h0);
      check("rst_rd", 64'(rd_addr), 64'h0);
      check("rst_wr", 64'(wr_addr), 64'h0);
      check("rst_wd", 64'(wr_data), 64'h0);
      check("rst_err", 64'(errCount), 64'h0);
      check("rst_valid", 64'(inPacketIsValid), 64'h0);
      check("rst_out", 64'(outPacket), 64'h420);
      @(negedge clk);
      reset = 1'b0;
      idle(1);

      // Error counter saturation
      for (int i = 0; i < 254; i++) begin
         send(12'hC25, 1'b0);
         idle(1);
      end
      check("sat_254", 64'(errCount), 64'hFE);
      send(12'hC25, 1'b0); idle(1);
      check("sat_255", 64'(errCount), 64'hFF);
      send(12'hC25, 1'b0); idle(1);
      check("sat_256", 64'(errCount), 64'hFF);
      check("sat_rd", 64'(rd_addr), 64'h0);

      // Randomized stream
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         if (r >= 8 && r < 14) pulse_fs();
         if ($urandom_range(0, 3) != 0) p = pk8(8'($urandom));
         else p = 12'($urandom);
         send(p, r < 8);
         idle(int'($urandom_range(2, 4)));
      end

      // 16-bit word / four-chunk configuration
      fs2 = 1'b1; dr2 = 1'b1; pkt2 = 24'h4420E4;
      @(negedge clk);
      fs2 = 1'b0; dr2 = 1'b0;
      check("p16_valid", 64'(v2), 64'h1);
      check("p16_rd", 64'(rd2), 64'h34);
      check("p16_err0", 64'(err2), 64'h0);
      idle(2);
      check("p16_out", 64'(out2), 64'h4000E4);
      dr2 = 1'b1; pkt2 = 24'h4620E4;
      @(negedge clk);
      dr2 = 1'b0;
      check("p16_bad_valid", 64'(v2), 64'h0);
      check("p16_bad_err", 64'(err2), 64'h1);
      check("p16_bad_rd", 64'(rd2), 64'h34);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memif_stream.md
# memif_stream

Parametrised successor to the SPI memory interface. Sits between the SPI serdes (one packet per `dataReady` strobe) and a dual-port memory with a 1-cycle registered read port. Each frame is a read-address packet, then a write-address packet, then a stream of data packets; each data packet writes one word and returns one read word, and both addresses auto-increment. Adds configurable chunking, frame restart, framing-error counting and read prefetch.

## Interface
- `WORD_WIDTH`, 8, data word bits; also the address-packet payload width.
- `ADDR_WIDTH`, 8, memory address bits; must be ≤ `WORD_WIDTH`.
- `CHUNK_WIDTH`, 4, payload bits per tagged chunk.
  - `CHUNKS = WORD_WIDTH/CHUNK_WIDTH`, which must be ≥2.
  - `PACKET_WIDTH = WORD_WIDTH + 2*CHUNKS`.
- `ERR_WIDTH`, 8, width of the error counter.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `frameStart`  in  1  single-cycle pulse at SPI chip-select assertion.
- `dataReady`  in  1  single-cycle strobe: `inPacket` is complete and stable.
- `inPacket`  in  PACKET_WIDTH  received packet.
- `outPacket`  out  PACKET_WIDTH  packet the serdes shifts out during the next packet.
- `rd_addr`  out  ADDR_WIDTH  memory read address.
- `rd_data`  in  WORD_WIDTH  memory read data, valid 1 cycle after `rd_addr`.
- `wr_addr`  out  ADDR_WIDTH  memory write address.
- `wr_data`  out  WORD_WIDTH  memory write data.
- `wr_enable`  out  1  single-cycle write strobe.
- `inPacketIsValid`  out  1  validity of the most recently received packet.
- `errCount`  out  ERR_WIDTH  saturating count of invalid packets.

## Operation
- **Packet format:** chunks are ordered MSB first. Each chunk is `{tag[1:0], payload[CHUNK_WIDTH-1:0]}`.
  - Tags: first chunk `01`, middle chunks `00`, last chunk `10`.
  - Any other tag in any position makes the packet invalid.
  - The word is the concatenation of the payloads, MSB first.
- **States:** `GET_RD_ADDR` (reset state), `GET_WR_ADDR`, `STREAM`.
- **Valid packet on `dataReady`:**
  - In `GET_RD_ADDR`: `rd_addr` ← word[ADDR_WIDTH-1:0]; go to `GET_WR_ADDR`.
  - In `GET_WR_ADDR`: `wr_addr` ← word[ADDR_WIDTH-1:0]; go to `STREAM`.
  - In `STREAM`: write the word to `wr_addr`, post-increment `wr_addr`, increment `rd_addr`. Stay in `STREAM`.
- **Invalid packet:** no state change, no write, no address change; `errCount` += 1, saturating at all-ones.
- **`inPacketIsValid`:** registered on every `dataReady` and held until the next one.
- **`frameStart`:** returns the FSM to `GET_RD_ADDR`. Addresses and `errCount` are unchanged.
- **Simultaneous `frameStart` and `dataReady`:** the packet is processed as the read-address packet of the new frame.
- **Prefetch:** whenever `rd_addr` changes, `outPacket` ← pack(`rd_data`) two cycles later.
- **Address wrap:** both addresses wrap modulo 2^ADDR_WIDTH (all-ones + 1 → 0).
- **Reset values:**
  - State `GET_RD_ADDR`.
  - `rd_addr` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `wr_enable` = 0, `inPacketIsValid` = 0, `errCount` = 0.
  - `outPacket` = pack(0).
- **Reset mid-frame:** aborts immediately. Any pending write strobe is cancelled.

## Timing
- `dataReady` is sampled at edge T.
- The decision (state, `inPacketIsValid`, `errCount`) is registered at T.
- **Write:** `wr_enable` is high for exactly the cycle T..T+1, with `wr_addr`/`wr_data` valid. `wr_addr` increments at T+1.
- **Read:** `rd_addr` updates at T. Memory returns `rd_data` at T+1. `outPacket` updates at T+2.
- **Throughput:** minimum `dataReady` spacing is 3 cycles. Closer strobes are still decoded, but `outPacket` may be stale.
- **No combinational path** from any input to any output.

## Structure
- Shared package `memif_pkg` holds:
  - Tag constants `TAG_FIRST=2'b01`, `TAG_MID=2'b00`, `TAG_LAST=2'b10`.
  - State enum `memif_state_t`.
  - `pack_word`/`unpack_word` functions parametrised by width.
- One sub-module, `memif_packet_codec`: combinational unpack plus tag validation (word and valid flag), and pack for `outPacket`. Its output feeds the FSM.

## Test plan
Defaults apply; the fake memory returns `rd_data` = `rd_addr`.
- **Basic frame:**
  - `frameStart`, then `inPacket`=0x425 (addr 0x05) → `rd_addr`=0x05 and `outPacket`=0x425 two cycles later.
  - Then 0x42D (addr 0x0D) → `wr_addr`=0x0D.
  - Then 0x56F → `wr_enable` one cycle, `wr_data`=0x5F at addr 0x0D; `wr_addr`=0x0E, `rd_addr`=0x06, `outPacket`=0x426.
- **Invalid tag:** 0xC25 in `STREAM` → `inPacketIsValid`=0, `errCount`=1, no `wr_enable`, addresses unchanged; the next valid packet writes normally.
- **Wrap:** write address 0xFF, two data packets → writes at 0xFF then 0x00.
- **Restart:** `frameStart` coincident with `dataReady` carrying 0x42A in `STREAM` → `rd_addr`=0x0A, state `GET_WR_ADDR`.
- **Reset:** async `reset` asserted during `wr_enable` → all outputs at reset values before the next edge. 256 invalid packets → `errCount` saturates at 0xFF.
- **Parameter sweep:** `WORD_WIDTH`=16, `CHUNK_WIDTH`=4 → 4-chunk packets 01/00/00/10 accepted; a packet with a middle tag of 10 is rejected.
